id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly upstream of the ALU in the RV32I core.
- Captures decoded operands and control, resolves EX/MEM and MEM/WB forwarding, and selects PC/immediate sources.
- Presents registered operand_a, operand_b and alu_op to the ALU.
- Valid/ready handshake on both sides; flush support for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard held and incoming instruction.
- in_valid  in  1  decode stage has an instruction.
- in_ready  out  1  stage can accept this cycle.
- rs1_addr, rs2_addr  in  REG_ADDR_W  source indices.
- rs1_data, rs2_data  in  XLEN  register-file read data.
- imm  in  XLEN  sign-extended immediate.
- pc  in  XLEN  instruction address.
- alu_op_in  in  alu_op_t  decoded ALU operation.
- alu_src_imm  in  1  operand_b = imm.
- alu_src_pc  in  1  operand_a = pc.
- rd_addr_in  in  REG_ADDR_W  destination index.
- reg_write_in  in  1  instruction writes rd.
- exmem_rd  in  REG_ADDR_W  EX/MEM destination.
- exmem_reg_write  in  1  EX/MEM writes.
- exmem_result  in  XLEN  EX/MEM value.
- memwb_rd  in  REG_ADDR_W  MEM/WB destination.
- memwb_reg_write  in  1  MEM/WB writes.
- memwb_result  in  XLEN  MEM/WB value.
- out_valid  out  1  outputs hold a live instruction.
- out_ready  in  1  ALU/EX stage accepts.
- operand_a, operand_b  out  XLEN  to ALU.
- alu_op  out  alu_op_t  to ALU.
- store_data  out  XLEN  forwarded rs2 for stores.
- rd_addr_out  out  REG_ADDR_W  destination.
- reg_write_out  out  1  gated write enable.

Behaviour:
- Reset (async assert, sync release): out_valid=0, operands/store_data/rd_addr_out=0, alu_op=ALU_ADD, reg_write_out=0.
- in_ready = !out_valid || out_ready. This is combinational and must not depend on in_valid.
- Capture on rising clk when in_valid && in_ready. Latency is 1 cycle from capture to out_valid=1.
- Hold: out_valid && !out_ready keeps all outputs stable, and in_ready=0.
- Drain: out_ready with no capture means out_valid=0 next cycle.
- Back-to-back: transfer out and capture in the same cycle gives a new instruction next cycle with no bubble.
- Flush dominates:
  - next cycle out_valid=0 and reg_write_out=0;
  - the incoming instruction is dropped even if in_valid;
  - in_ready=1 during flush.
- reg_write_out = captured reg_write_in && out_valid. It is never 1 on a bubble.
- Forwarding per source, evaluated at capture time:
  - if rsX_addr==0, value=0 (x0 hardwired);
  - else if exmem_reg_write && exmem_rd==rsX_addr, use exmem_result;
  - else if memwb_reg_write && memwb_rd==rsX_addr, use memwb_result;
  - else use rsX_data.
  - EX/MEM beats MEM/WB when both match.
- Operand select:
  - operand_a = alu_src_pc ? pc : fwd_rs1;
  - operand_b = alu_src_imm ? imm : fwd_rs2;
  - store_data = fwd_rs2 regardless of alu_src_imm.
- Held values are not re-forwarded. Load-use hazards are handled by upstream stall (in_valid=0 or decode hold); this stage does not detect them.
- All arithmetic is XLEN-wide with no extension. Selection only; no computation happens in this block.

Decomposition:
- riscv_pkg already holds alu_op_t.
- riscv_pkg gains:
  - fwd_sel_t enum {FWD_RF, FWD_EXMEM, FWD_MEMWB, FWD_ZERO};
  - id_ex_t packed struct of all captured fields;
  - REG_ZERO constant.
- One sub-module: fwd_mux (combinational priority select producing fwd_sel_t and value), instantiated for rs1 and rs2.

Test Plan:
- Reset mid-stream, asserted while out_valid=1 -> outputs immediately 0, alu_op=ALU_ADD, out_valid=0, reg_write_out=0.
- Plain capture: rs1=5/data 10, rs2=6/data 15, ALU_ADD, no forwarding, out_ready=1 -> next cycle operand_a=10, operand_b=15, out_valid=1. Chained ALU gives 25.
- Forward priority: rs1=3, exmem_rd=3 result 0x30, memwb_rd=3 result 0x40, rs1_data 0x99 -> operand_a=0x30. With exmem_reg_write=0 -> 0x40. With rs1=0 -> 0.
- Immediate/PC select: alu_src_pc=1, pc=0x100, alu_src_imm=1, imm=0xFFFFFFFC, rs2 forwarded 0x55 -> operand_a=0x100, operand_b=0xFFFFFFFC, store_data=0x55.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Then out_ready=1 -> the second instruction appears next cycle with no loss or duplication.
- Flush during hold plus incoming in_valid=1 -> next cycle out_valid=0, reg_write_out=0, incoming dropped. The following instruction is captured normally.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I core types: ALU operations, forwarding selects and the ID/EX payload.
package riscv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_t;

  typedef enum logic [1:0] {
    FWD_RF    = 2'd0,
    FWD_EXMEM = 2'd1,
    FWD_MEMWB = 2'd2,
    FWD_ZERO  = 2'd3
  } fwd_sel_t;

  typedef struct packed {
    logic [XLEN-1:0]       operand_a;
    logic [XLEN-1:0]       operand_b;
    logic [XLEN-1:0]       store_data;
    alu_op_t               alu_op;
    logic [REG_ADDR_W-1:0] rd_addr;
  } id_ex_t;

endpackage

// File: rtl/fwd_mux.sv
// Priority operand forwarding for one source register: x0, then EX/MEM, then MEM/WB, then RF.
module fwd_mux
  import riscv_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_rs_addr,
  input  logic [XLEN-1:0]       i_rs_data,
  input  logic [REG_ADDR_W-1:0] i_exmem_rd,
  input  logic                  i_exmem_reg_write,
  input  logic [XLEN-1:0]       i_exmem_result,
  input  logic [REG_ADDR_W-1:0] i_memwb_rd,
  input  logic                  i_memwb_reg_write,
  input  logic [XLEN-1:0]       i_memwb_result,
  output fwd_sel_t              o_sel,
  output logic [XLEN-1:0]       o_value
);

  always_comb begin
    o_sel = FWD_RF;
    if (i_rs_addr == REG_ZERO) begin
      o_sel = FWD_ZERO;
    end else if (i_exmem_reg_write && (i_exmem_rd == i_rs_addr)) begin
      o_sel = FWD_EXMEM;
    end else if (i_memwb_reg_write && (i_memwb_rd == i_rs_addr)) begin
      o_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    o_value = i_rs_data;
    case (o_sel)
      FWD_ZERO:  o_value = '0;
      FWD_EXMEM: o_value = i_exmem_result;
      FWD_MEMWB: o_value = i_memwb_result;
      default:   o_value = i_rs_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards sources, selects PC/imm operands and registers them for the ALU.
module id_ex_stage
  import riscv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic [XLEN-1:0]       rs1_data,
  input  logic [XLEN-1:0]       rs2_data,
  input  logic [XLEN-1:0]       imm,
  input  logic [XLEN-1:0]       pc,
  input  alu_op_t               alu_op_in,
  input  logic                  alu_src_imm,
  input  logic                  alu_src_pc,
  input  logic [REG_ADDR_W-1:0] rd_addr_in,
  input  logic                  reg_write_in,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  input  logic [XLEN-1:0]       memwb_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       operand_a,
  output logic [XLEN-1:0]       operand_b,
  output alu_op_t               alu_op,
  output logic [XLEN-1:0]       store_data,
  output logic [REG_ADDR_W-1:0] rd_addr_out,
  output logic                  reg_write_out
);

  fwd_sel_t        w_rs1_sel;
  fwd_sel_t        w_rs2_sel;
  logic [XLEN-1:0] w_rs1_fwd;
  logic [XLEN-1:0] w_rs2_fwd;
  logic            w_capture;
  logic            w_unused_sel;
  id_ex_t          w_next;
  id_ex_t          r_stage;
  logic            r_valid;
  logic            r_reg_write;

  fwd_mux u_fwd_rs1 (
    .i_rs_addr         (rs1_addr),
    .i_rs_data         (rs1_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_sel             (w_rs1_sel),
    .o_value           (w_rs1_fwd)
  );

  fwd_mux u_fwd_rs2 (
    .i_rs_addr         (rs2_addr),
    .i_rs_data         (rs2_data),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_result    (exmem_result),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_result    (memwb_result),
    .o_sel             (w_rs2_sel),
    .o_value           (w_rs2_fwd)
  );

  // Select codes are kept for debug visibility; only the values feed the pipeline.
  assign w_unused_sel = ^{w_rs1_sel, w_rs2_sel};

  // Flush always opens the stage so the flushed slot is freed this cycle.
  assign in_ready  = flush || !r_valid || out_ready;
  assign w_capture = in_valid && in_ready && !flush;

  always_comb begin
    w_next            = '0;
    w_next.operand_a  = alu_src_pc  ? pc  : w_rs1_fwd;
    w_next.operand_b  = alu_src_imm ? imm : w_rs2_fwd;
    w_next.store_data = w_rs2_fwd;
    w_next.alu_op     = alu_op_in;
    w_next.rd_addr    = rd_addr_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid          <= 1'b0;
      r_reg_write      <= 1'b0;
      r_stage          <= '0;
      r_stage.alu_op   <= ALU_ADD;
    end else if (flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end else if (w_capture) begin
      r_valid     <= 1'b1;
      r_reg_write <= reg_write_in;
      r_stage     <= w_next;
    end else if (out_ready) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
    end
  end

  assign out_valid     = r_valid;
  assign reg_write_out = r_reg_write;
  assign operand_a     = r_stage.operand_a;
  assign operand_b     = r_stage.operand_b;
  assign store_data    = r_stage.store_data;
  assign alu_op        = r_stage.alu_op;
  assign rd_addr_out   = r_stage.rd_addr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: capture, forwarding priority, operand select, backpressure, flush, reset.
module tb_id_ex_stage;
  import riscv_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [REG_ADDR_W-1:0] rs1_addr, rs2_addr;
  logic [XLEN-1:0]       rs1_data, rs2_data, imm, pc;
  alu_op_t               alu_op_in;
  logic                  alu_src_imm, alu_src_pc;
  logic [REG_ADDR_W-1:0] rd_addr_in;
  logic                  reg_write_in;
  logic [REG_ADDR_W-1:0] exmem_rd, memwb_rd;
  logic                  exmem_reg_write, memwb_reg_write;
  logic [XLEN-1:0]       exmem_result, memwb_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [XLEN-1:0]       operand_a, operand_b, store_data;
  alu_op_t               alu_op;
  logic [REG_ADDR_W-1:0] rd_addr_out;
  logic                  reg_write_out;

  int checks   = 0;
  int failures = 0;

  id_ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_data        (rs1_data),
    .rs2_data        (rs2_data),
    .imm             (imm),
    .pc              (pc),
    .alu_op_in       (alu_op_in),
    .alu_src_imm     (alu_src_imm),
    .alu_src_pc      (alu_src_pc),
    .rd_addr_in      (rd_addr_in),
    .reg_write_in    (reg_write_in),
    .exmem_rd        (exmem_rd),
    .exmem_reg_write (exmem_reg_write),
    .exmem_result    (exmem_result),
    .memwb_rd        (memwb_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_result    (memwb_result),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .alu_op          (alu_op),
    .store_data      (store_data),
    .rd_addr_out     (rd_addr_out),
    .reg_write_out   (reg_write_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic [4:0] a1, input logic [31:0] d1,
                          input logic [4:0] a2, input logic [31:0] d2,
                          input alu_op_t op, input logic [4:0] rd, input logic rw);
    rs1_addr = a1; rs1_data = d1;
    rs2_addr = a2; rs2_data = d2;
    alu_op_in = op; rd_addr_in = rd; reg_write_in = rw;
    alu_src_imm = 1'b0; alu_src_pc = 1'b0;
    imm = 32'h0; pc = 32'h0;
  endtask

  task automatic no_fwd();
    exmem_rd = 5'd0; exmem_reg_write = 1'b0; exmem_result = 32'h0;
    memwb_rd = 5'd0; memwb_reg_write = 1'b0; memwb_result = 32'h0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    set_inst(5'd0, 32'h0, 5'd0, 32'h0, ALU_ADD, 5'd0, 1'b0);
    no_fwd();
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_operand_a", operand_a, 32'h0);
    check("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("rst_reg_write", 32'(reg_write_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;

    // Plain capture
    set_inst(5'd5, 32'd10, 5'd6, 32'd15, ALU_ADD, 5'd7, 1'b1);
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("cap_out_valid", 32'(out_valid), 32'd1);
    check("cap_operand_a", operand_a, 32'd10);
    check("cap_operand_b", operand_b, 32'd15);
    check("cap_rd", 32'(rd_addr_out), 32'd7);
    check("cap_reg_write", 32'(reg_write_out), 32'd1);
    check("cap_alu_sum", operand_a + operand_b, 32'd25);

    // Forward priority: EX/MEM beats MEM/WB beats RF
    set_inst(5'd3, 32'h99, 5'd6, 32'd15, ALU_ADD, 5'd8, 1'b1);
    exmem_rd = 5'd3; exmem_reg_write = 1'b1; exmem_result = 32'h30;
    memwb_rd = 5'd3; memwb_reg_write = 1'b1; memwb_result = 32'h40;
    step();
    check("fwd_exmem", operand_a, 32'h30);
    check("fwd_b2b_valid", 32'(out_valid), 32'd1);
    exmem_reg_write = 1'b0;
    step();
    check("fwd_memwb", operand_a, 32'h40);
    rs1_addr = 5'd0; exmem_rd = 5'd0; exmem_reg_write = 1'b1;
    step();
    check("fwd_x0", operand_a, 32'h0);

    // Immediate / PC select with forwarded store data
    no_fwd();
    set_inst(5'd1, 32'h77, 5'd9, 32'h11, ALU_ADD, 5'd10, 1'b0);
    alu_src_pc = 1'b1; pc = 32'h100;
    alu_src_imm = 1'b1; imm = 32'hFFFF_FFFC;
    exmem_rd = 5'd9; exmem_reg_write = 1'b1; exmem_result = 32'h55;
    step();
    check("sel_operand_a", operand_a, 32'h100);
    check("sel_operand_b", operand_b, 32'hFFFF_FFFC);
    check("sel_store_data", store_data, 32'h55);
    check("sel_reg_write", 32'(reg_write_out), 32'd0);

    // Backpressure: hold for three cycles with a waiting instruction
    no_fwd();
    set_inst(5'd1, 32'hB1, 5'd2, 32'hB2, ALU_SUB, 5'd11, 1'b1);
    out_ready = 1'b0;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_hold_a", operand_a, 32'h100);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("bp_new_a", operand_a, 32'hB1);
    check("bp_new_b", operand_b, 32'hB2);
    check("bp_new_op", 32'(alu_op), 32'(ALU_SUB));
    check("bp_new_rd", 32'(rd_addr_out), 32'd11);
    in_valid = 1'b0;
    step();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_reg_write", 32'(reg_write_out), 32'd0);

    // Flush during hold with an incoming instruction
    set_inst(5'd1, 32'hC1, 5'd2, 32'hC2, ALU_OR, 5'd12, 1'b1);
    in_valid = 1'b1;
    step();
    check("fl_pre_valid", 32'(out_valid), 32'd1);
    set_inst(5'd1, 32'hD1, 5'd2, 32'hD2, ALU_AND, 5'd13, 1'b1);
    out_ready = 1'b0; flush = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    step();
    check("fl_out_valid", 32'(out_valid), 32'd0);
    check("fl_reg_write", 32'(reg_write_out), 32'd0);
    flush = 1'b0;
    set_inst(5'd4, 32'hE4, 5'd2, 32'hE2, ALU_XOR, 5'd14, 1'b1);
    out_ready = 1'b1;
    step();
    check("fl_next_valid", 32'(out_valid), 32'd1);
    check("fl_next_a", operand_a, 32'hE4);
    check("fl_next_rd", 32'(rd_addr_out), 32'd14);

    // Asynchronous reset mid-stream
    in_valid = 1'b0; out_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_operand_a", operand_a, 32'h0);
    check("mrst_operand_b", operand_b, 32'h0);
    check("mrst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    check("mrst_reg_write", 32'(reg_write_out), 32'd0);
    step();
    rst = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
